// File: rtl/exe_sequencer_pkg.sv
// Shared definitions for the exe_sequencer control unit: opcodes, instruction
// field positions, FSM states and field-extraction helpers.
package exe_sequencer_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_PC_W   = 8;
   localparam int NUM_REGS   = 4;
   localparam int INSTR_W    = 16;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_MOV  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_JMP  = 3'b011;
   localparam logic [2:0] OP_LDI  = 3'b100;
   localparam logic [2:0] OP_HALT = 3'b101;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 13;
   localparam int RD_MSB  = 12;
   localparam int RD_LSB  = 11;
   localparam int RA_MSB  = 10;
   localparam int RA_LSB  = 9;
   localparam int RB_MSB  = 8;
   localparam int RB_LSB  = 7;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALTED
   } state_t;

   function automatic logic [2:0] f_op(input logic [INSTR_W-1:0] i);
      return i[OP_MSB:OP_LSB];
   endfunction

   function automatic logic [1:0] f_rd(input logic [INSTR_W-1:0] i);
      return i[RD_MSB:RD_LSB];
   endfunction

   function automatic logic [1:0] f_ra(input logic [INSTR_W-1:0] i);
      return i[RA_MSB:RA_LSB];
   endfunction

   function automatic logic [1:0] f_rb(input logic [INSTR_W-1:0] i);
      return i[RB_MSB:RB_LSB];
   endfunction

   function automatic logic [7:0] f_imm(input logic [INSTR_W-1:0] i);
      return i[IMM_MSB:IMM_LSB];
   endfunction

   function automatic logic is_wb_op(input logic [2:0] op);
      return (op == OP_MOV) || (op == OP_ADD) || (op == OP_LDI);
   endfunction

endpackage

// File: rtl/exe_regfile.sv
// 4-entry register file: two combinational read ports, one synchronous write
// port, asynchronous clear.
module exe_regfile
   import exe_sequencer_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        ra_addr,
   input  logic [1:0]        rb_addr,
   output logic [DATA_W-1:0] ra_data,
   output logic [DATA_W-1:0] rb_data,
   input  logic              we,
   input  logic [1:0]        waddr,
   input  logic [DATA_W-1:0] wdata
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign ra_data = regs[ra_addr];
   assign rb_data = regs[rb_addr];

endmodule

// File: rtl/exe_sequencer.sv
// Multicycle fetch/decode/execute controller driving the 16-bit execute unit
// and owning the PC, register file and opcode decode.
module exe_sequencer
   import exe_sequencer_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int PC_W   = DEF_PC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [15:0]       imem_data,
   output logic [DATA_W-1:0] exe_a,
   output logic [DATA_W-1:0] exe_b,
   output logic              exe_add,
   input  logic [DATA_W-1:0] exe_result,
   output logic              wb_en,
   output logic [1:0]        wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic [PC_W-1:0]   pc,
   output logic              busy,
   output logic              halted,
   output logic              illegal
);

   state_t            state, state_nx;
   logic [2:0]        ir_op;
   logic [1:0]        ir_rd;
   logic [7:0]        ir_imm;
   logic [DATA_W-1:0] rf_a, rf_b;

   // Operands are read straight off the returning instruction word in DECODE.
   exe_regfile #(.DATA_W(DATA_W)) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .ra_addr (f_ra(imem_data)),
      .rb_addr (f_rb(imem_data)),
      .ra_data (rf_a),
      .rb_data (rf_b),
      .we      (wb_en),
      .waddr   (wb_addr),
      .wdata   (wb_data)
   );

   assign imem_addr = pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (start) state_nx = S_FETCH;
         S_FETCH:  state_nx = S_DECODE;
         S_DECODE: state_nx = S_EXEC;
         S_EXEC: begin
            if (is_wb_op(ir_op))       state_nx = S_WB;
            else if (ir_op == OP_HALT) state_nx = S_HALTED;
            else                       state_nx = S_FETCH;
         end
         S_WB:     state_nx = S_FETCH;
         S_HALTED: if (start) state_nx = S_FETCH;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      busy    = 1'b0;
      halted  = 1'b0;
      wb_en   = 1'b0;
      illegal = 1'b0;
      case (state)
         S_FETCH, S_DECODE: busy = 1'b1;
         S_EXEC: begin
            busy    = 1'b1;
            illegal = (ir_op > OP_HALT);
         end
         S_WB: begin
            busy  = 1'b1;
            wb_en = 1'b1;
         end
         S_HALTED: halted = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc      <= '0;
         ir_op   <= '0;
         ir_rd   <= '0;
         ir_imm  <= '0;
         exe_a   <= '0;
         exe_b   <= '0;
         exe_add <= 1'b0;
         wb_addr <= '0;
         wb_data <= '0;
      end else begin
         case (state)
            S_DECODE: begin
               ir_op  <= f_op(imem_data);
               ir_rd  <= f_rd(imem_data);
               ir_imm <= f_imm(imem_data);
               case (f_op(imem_data))
                  OP_MOV: begin
                     exe_a   <= rf_a;
                     exe_b   <= rf_b;
                     exe_add <= 1'b0;
                  end
                  OP_ADD: begin
                     exe_a   <= rf_a;
                     exe_b   <= rf_b;
                     exe_add <= 1'b1;
                  end
                  OP_LDI: begin
                     exe_a   <= '0;
                     exe_b   <= DATA_W'(f_imm(imem_data));
                     exe_add <= 1'b0;
                  end
                  default: begin
                     exe_a   <= '0;
                     exe_b   <= '0;
                     exe_add <= 1'b0;
                  end
               endcase
            end
            S_EXEC: begin
               if (is_wb_op(ir_op)) begin
                  wb_data <= exe_result;
                  wb_addr <= ir_rd;
               end else if (ir_op == OP_JMP) begin
                  pc <= PC_W'(ir_imm);
               end else if (ir_op != OP_HALT) begin
                  pc <= pc + 1'b1;
               end
            end
            S_WB:     pc <= pc + 1'b1;
            S_HALTED: if (start) pc <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_exe_sequencer.sv
// Directed bench for exe_sequencer with a behavioural imem and execute unit.
module tb_exe_sequencer;

   localparam logic [2:0] T_MOV  = 3'b001;
   localparam logic [2:0] T_ADD  = 3'b010;
   localparam logic [2:0] T_JMP  = 3'b011;
   localparam logic [2:0] T_LDI  = 3'b100;
   localparam logic [15:0] T_HALT = 16'hA000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  imem_addr;
   logic [15:0] imem_data;
   logic [15:0] exe_a, exe_b, exe_result, wb_data;
   logic        exe_add, wb_en, busy, halted, illegal;
   logic [1:0]  wb_addr;
   logic [7:0]  pc;

   logic [15:0] imem [256];

   int n_tests = 0;
   int n_fail  = 0;

   int          cyc = 0;
   logic        prev_busy = 1'b0;
   logic [7:0]  prev_addr = '0;
   int          ill_cnt = 0;
   logic [1:0]  wba_q [$];
   logic [15:0] wbd_q [$];
   int          wbc_q [$];
   logic [7:0]  fa_q  [$];
   int          fac_q [$];

   exe_sequencer #(.DATA_W(16), .PC_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .exe_a      (exe_a),
      .exe_b      (exe_b),
      .exe_add    (exe_add),
      .exe_result (exe_result),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .pc         (pc),
      .busy       (busy),
      .halted     (halted),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   always @(posedge clk) imem_data <= imem[imem_addr];
   assign exe_result = exe_add ? exe_a + exe_b : exe_b;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (wb_en) begin
         wba_q.push_back(wb_addr);
         wbd_q.push_back(wb_data);
         wbc_q.push_back(cyc);
      end
      if (illegal) ill_cnt = ill_cnt + 1;
      if (busy && (!prev_busy || imem_addr != prev_addr)) begin
         fa_q.push_back(imem_addr);
         fac_q.push_back(cyc);
      end
      prev_busy = busy;
      prev_addr = imem_addr;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] rr(input logic [2:0] op, input logic [1:0] rd,
                                      input logic [1:0] ra, input logic [1:0] rb);
      return {op, rd, ra, rb, 7'd0};
   endfunction

   function automatic logic [15:0] ri(input logic [2:0] op, input logic [1:0] rd,
                                      input logic [7:0] imm);
      return {op, rd, 3'd0, imm};
   endfunction

   task automatic clear_imem();
      for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_halted(input string tag, input int budget);
      int n = 0;
      while (!halted && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'd0, halted}, 32'd1);
   endtask

   task automatic chk_wb(input string tag, input int idx, input logic [1:0] a, input logic [15:0] d);
      if (idx < wba_q.size()) begin
         chk({tag, "_addr"}, {30'd0, wba_q[idx]}, {30'd0, a});
         chk({tag, "_data"}, {16'd0, wbd_q[idx]}, {16'd0, d});
      end else begin
         chk({tag, "_present"}, 32'd0, 32'd1);
      end
   endtask

   initial begin
      int wb0, fa0, il0, n;

      clear_imem();
      @(negedge clk);
      chk("rst_pc", {24'd0, pc}, 32'd0);
      chk("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
      chk("rst_flags", {28'd0, busy, halted, wb_en, illegal}, 32'd0);
      chk("rst_exe", {15'd0, exe_add, exe_a}, 32'd0);
      chk("rst_wb", {14'd0, wb_addr, wb_data}, 32'd0);
      rst = 1'b0;

      // LDI/LDI/ADD/HALT
      imem[0] = ri(T_LDI, 2'd1, 8'h12);
      imem[1] = ri(T_LDI, 2'd2, 8'h34);
      imem[2] = rr(T_ADD, 2'd3, 2'd1, 2'd2);
      imem[3] = T_HALT;
      wb0 = wba_q.size();
      pulse_start();
      wait_halted("t1_halt", 60);
      chk("t1_wb_count", wba_q.size() - wb0, 32'd3);
      chk_wb("t1_wb0", wb0,     2'd1, 16'h0012);
      chk_wb("t1_wb1", wb0 + 1, 2'd2, 16'h0034);
      chk_wb("t1_wb2", wb0 + 2, 2'd3, 16'h0046);
      if (wbc_q.size() >= wb0 + 3)
         chk("t1_add_latency", wbc_q[wb0 + 2] - wbc_q[wb0 + 1], 32'd4);
      chk("t1_pc", {24'd0, pc}, 32'd3);
      chk("t1_halt_exe", {15'd0, exe_add, exe_a | exe_b}, 32'd0);

      // restart from HALTED, registers retained
      clear_imem();
      imem[0] = rr(T_MOV, 2'd0, 2'd0, 2'd3);
      imem[1] = T_HALT;
      wb0 = wba_q.size();
      fa0 = fa_q.size();
      pulse_start();
      wait_halted("t5_halt", 40);
      chk("t5_first_addr", (fa_q.size() > fa0) ? {24'd0, fa_q[fa0]} : 32'hFFFF, 32'd0);
      chk("t5_wb_count", wba_q.size() - wb0, 32'd1);
      chk_wb("t5_wb0", wb0, 2'd0, 16'h0046);
      chk("t5_pc", {24'd0, pc}, 32'd1);

      // doubling to 0xFF00, then 0xFFFF+1 wraps to 0 with no carry left over
      clear_imem();
      imem[0] = ri(T_LDI, 2'd0, 8'hFF);
      for (int i = 1; i <= 8; i++) imem[i] = rr(T_ADD, 2'd0, 2'd0, 2'd0);
      imem[9]  = ri(T_LDI, 2'd1, 8'hFF);
      imem[10] = rr(T_ADD, 2'd0, 2'd0, 2'd1);
      imem[11] = ri(T_LDI, 2'd2, 8'h01);
      imem[12] = rr(T_ADD, 2'd3, 2'd0, 2'd2);
      imem[13] = rr(T_ADD, 2'd2, 2'd2, 2'd2);
      imem[14] = T_HALT;
      wb0 = wba_q.size();
      pulse_start();
      wait_halted("t2_halt", 300);
      chk("t2_wb_count", wba_q.size() - wb0, 32'd14);
      chk_wb("t2_ff00", wb0 + 8,  2'd0, 16'hFF00);
      chk_wb("t2_ffff", wb0 + 10, 2'd0, 16'hFFFF);
      chk_wb("t2_wrap", wb0 + 12, 2'd3, 16'h0000);
      chk_wb("t2_nocarry", wb0 + 13, 2'd2, 16'h0002);
      chk("t2_pc", {24'd0, pc}, 32'd14);

      // JMP 5 -> HALT
      do_reset();
      clear_imem();
      imem[0] = ri(T_JMP, 2'd0, 8'h05);
      imem[5] = T_HALT;
      wb0 = wba_q.size();
      fa0 = fa_q.size();
      pulse_start();
      wait_halted("t3_halt", 40);
      chk("t3_fetch_count", fa_q.size() - fa0, 32'd2);
      if (fa_q.size() >= fa0 + 2) begin
         chk("t3_addr0", {24'd0, fa_q[fa0]}, 32'd0);
         chk("t3_addr1", {24'd0, fa_q[fa0 + 1]}, 32'd5);
         chk("t3_jmp_latency", fac_q[fa0 + 1] - fac_q[fa0], 32'd3);
      end
      chk("t3_no_wb", wba_q.size() - wb0, 32'd0);
      chk("t3_pc", {24'd0, pc}, 32'd5);

      // reserved opcode 111 then HALT
      do_reset();
      clear_imem();
      imem[0] = 16'hE000;
      imem[1] = T_HALT;
      wb0 = wba_q.size();
      il0 = ill_cnt;
      pulse_start();
      wait_halted("t4_halt", 40);
      chk("t4_illegal_cycles", ill_cnt - il0, 32'd1);
      chk("t4_no_wb", wba_q.size() - wb0, 32'd0);
      chk("t4_pc", {24'd0, pc}, 32'd1);

      // reset during EXEC of an ADD
      do_reset();
      clear_imem();
      imem[0] = ri(T_LDI, 2'd1, 8'h05);
      imem[1] = rr(T_ADD, 2'd2, 2'd1, 2'd1);
      imem[2] = T_HALT;
      wb0 = wba_q.size();
      pulse_start();
      n = 0;
      while (!wb_en && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("t6_ldi_wb_seen", {31'd0, wb_en}, 32'd1);
      repeat (3) @(negedge clk);
      chk("t6_exec_operands", {exe_add, 15'd0, exe_a}, {1'b1, 15'd0, 16'h0005});
      rst = 1'b1;
      #1;
      chk("t6_rst_pc", {24'd0, pc}, 32'd0);
      chk("t6_rst_flags", {28'd0, busy, halted, wb_en, illegal}, 32'd0);
      chk("t6_rst_outs", {exe_add, exe_a, wb_addr == 2'd0 && wb_data == 16'd0 && exe_b == 16'd0}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("t6_no_add_wb", wba_q.size() - wb0, 32'd1);
      clear_imem();
      imem[0] = rr(T_ADD, 2'd3, 2'd2, 2'd1);
      imem[1] = T_HALT;
      wb0 = wba_q.size();
      fa0 = fa_q.size();
      pulse_start();
      wait_halted("t6_resume_halt", 40);
      chk("t6_resume_addr", (fa_q.size() > fa0) ? {24'd0, fa_q[fa0]} : 32'hFFFF, 32'd0);
      chk("t6_resume_wb_count", wba_q.size() - wb0, 32'd1);
      chk_wb("t6_regs_cleared", wb0, 2'd3, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
